// File: rtl/operm_pkg.sv
// rtl/operm_pkg.sv - shared widths, lane-map type and scheduler state codes
package operm_pkg;
  localparam int OPERM_LANES = 16;
  localparam int OPERM_DW    = 32;
  localparam int OPERM_KPW   = 68;
  localparam int OPERM_IDXW  = 4;
  localparam int OPERM_VW    = OPERM_LANES * OPERM_DW;
  localparam int OPERM_MAPW  = OPERM_LANES * OPERM_IDXW;

  typedef logic [OPERM_LANES-1:0][OPERM_IDXW-1:0] operm_map_t;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
endpackage

// File: rtl/operm_sched_if.sv
// rtl/operm_sched_if.sv - requester and response handshake bundle
interface operm_sched_if
  import operm_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) ();
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*OPERM_VW-1:0] req_dat;
  logic [NREQ*OPERM_MAPW-1:0] req_kp;
  logic [NREQ*4-1:0]        req_ctrl;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [OPERM_VW-1:0]      rsp_dat;
  logic [IDW-1:0]           rsp_id;
  logic [3:0]               rsp_ctrl;
  logic                     rsp_err;

  modport slave (
    input  req_valid, req_dat, req_kp, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_dat, rsp_id, rsp_ctrl, rsp_err
  );
  modport master (
    output req_valid, req_dat, req_kp, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_dat, rsp_id, rsp_ctrl, rsp_err
  );
endinterface

// File: rtl/operm_rr_arb.sv
// rtl/operm_rr_arb.sv - round-robin arbiter, one-hot grant, pointer advances past the winner
module operm_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_vld
);
  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

  logic [IDW-1:0] ptr;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      idx = sum[IDW-1:0];
      if (en && !gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: rtl/operm_sched.sv
// rtl/operm_sched.sv - round-robin front end for the operand permutation network:
// issue register feeding the network, response register with backpressure, flush/drain.
module operm_sched
  import operm_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  operm_sched_if.slave         io,
  output logic [OPERM_VW-1:0]  t_dat_dat,
  output logic [OPERM_KPW-1:0] t_kp_dat,
  input  logic [OPERM_VW-1:0]  i_dat_dat,
  input  logic [3:0]           k_ctrl,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 busy
);
  logic [1:0]            state;
  logic                  a_vld, a_err, b_vld, b_err;
  logic [OPERM_VW-1:0]   a_dat, b_dat;
  operm_map_t            a_map;
  logic [3:0]            a_ctrl, b_ctrl;
  logic [IDW-1:0]        a_id, b_id;
  logic                  b_load, a_free, arb_en, gnt_vld;
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        gnt_idx;
  operm_map_t            sel_map;
  logic [OPERM_LANES-1:0] seen;
  logic                  sel_err;

  assign b_load = a_vld && (!b_vld || io.rsp_ready);
  assign a_free = !a_vld || b_load;
  assign arb_en = reset_n && (state == ST_RUN) && !flush && a_free;

  operm_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk     (clk),
    .rst_n   (reset_n),
    .en      (arb_en),
    .req     (io.req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign io.req_ready = gnt;
  assign sel_map = operm_map_t'(io.req_kp[int'(gnt_idx)*OPERM_MAPW +: OPERM_MAPW]);

  // A map is a bijection exactly when every lane index is hit once.
  always_comb begin
    seen = '0;
    for (int i = 0; i < OPERM_LANES; i++) seen[sel_map[i]] = 1'b1;
    sel_err = ($countones(seen) != OPERM_LANES);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_vld  <= 1'b0;
      a_dat  <= '0;
      a_map  <= '0;
      a_ctrl <= '0;
      a_id   <= '0;
      a_err  <= 1'b0;
    end else if (gnt_vld) begin
      a_vld  <= 1'b1;
      a_dat  <= io.req_dat[int'(gnt_idx)*OPERM_VW +: OPERM_VW];
      a_map  <= sel_map;
      a_ctrl <= io.req_ctrl[int'(gnt_idx)*4 +: 4];
      a_id   <= gnt_idx;
      a_err  <= sel_err;
    end else if (b_load) begin
      a_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_vld  <= 1'b0;
      b_dat  <= '0;
      b_ctrl <= '0;
      b_id   <= '0;
      b_err  <= 1'b0;
    end else if (b_load) begin
      b_vld  <= 1'b1;
      b_dat  <= i_dat_dat;
      b_ctrl <= k_ctrl;
      b_id   <= a_id;
      b_err  <= a_err;
    end else if (io.rsp_ready) begin
      b_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (flush) state <= ST_DRAIN;
        ST_DRAIN: if (!a_vld && !b_vld) state <= ST_HOLD;
        ST_HOLD:  if (!flush) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  assign flush_done   = (state == ST_DRAIN) && !a_vld && !b_vld;
  assign busy         = a_vld | b_vld;
  assign t_dat_dat    = a_dat;
  assign t_kp_dat     = {a_ctrl, a_map};
  assign io.rsp_valid = b_vld;
  assign io.rsp_dat   = b_dat;
  assign io.rsp_id    = b_id;
  assign io.rsp_ctrl  = b_ctrl;
  assign io.rsp_err   = b_err;
endmodule

// File: tb/tb_operm_sched.sv
// tb/tb_operm_sched.sv - randomized bench for operm_sched against a queue-based reference model
module tb_operm_sched;
  import operm_pkg::*;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         flush_done, busy;
  logic [511:0] t_dat_dat, i_dat_dat;
  logic [67:0]  t_kp_dat;
  logic [3:0]   k_ctrl;

  always #5 clk = ~clk;

  operm_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  operm_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .io         (bus),
    .t_dat_dat  (t_dat_dat),
    .t_kp_dat   (t_kp_dat),
    .i_dat_dat  (i_dat_dat),
    .k_ctrl     (k_ctrl),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy)
  );

  // Network: output lane i takes input lane map[i].
  function automatic logic [511:0] permute(input logic [511:0] d, input logic [63:0] m);
    logic [511:0] o;
    logic [3:0]   s;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      s = m[4*i +: 4];
      o[32*i +: 32] = d[32*int'(s) +: 32];
    end
    return o;
  endfunction

  function automatic logic has_dup(input logic [63:0] m);
    for (int i = 0; i < 16; i++)
      for (int j = i + 1; j < 16; j++)
        if (m[4*i +: 4] == m[4*j +: 4]) return 1'b1;
    return 1'b0;
  endfunction

  always_comb begin
    i_dat_dat = permute(t_dat_dat, t_kp_dat[63:0]);
    k_ctrl    = t_kp_dat[67:64];
  end

  typedef struct {
    int           id;
    logic [511:0] dat;
    logic [3:0]   ctrl;
    logic         err;
    int           age;
  } ent_t;

  ent_t q[$];
  int   ptr = 0;
  int   mode = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   fd_seen = 0;
  bit   keep_fields = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model view: a two-entry in-order pipe; an entry is visible once it has
  // survived one clock edge, and a new entry fits if the pipe is not full or its head leaves.
  task automatic model_cycle();
    logic [NREQ-1:0] exp_rdy;
    int   g;
    bit   vis, pop, ok;
    ent_t e;
    vis = (q.size() > 0) && (q[0].age >= 1);
    pop = vis && bus.rsp_ready;
    ok  = (mode == 0) && !flush && ((q.size() < 2) || pop);
    exp_rdy = '0;
    g = -1;
    if (ok) begin
      for (int k = 0; k < NREQ; k++) begin
        int r;
        r = (ptr + k) % NREQ;
        if (g < 0 && bus.req_valid[r]) g = r;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("rsp_valid", bus.rsp_valid, vis);
    chk("busy", busy, q.size() > 0);
    chk("flush_done", flush_done, (mode == 1) && (q.size() == 0));
    if (flush_done) fd_seen++;
    if (vis) begin
      chk("rsp_dat", bus.rsp_dat, q[0].dat);
      chk("rsp_id", bus.rsp_id, q[0].id);
      chk("rsp_ctrl", bus.rsp_ctrl, q[0].ctrl);
      chk("rsp_err", bus.rsp_err, q[0].err);
    end
    if (mode == 1 && q.size() == 0) mode = 2;
    else if (mode == 0 && flush) mode = 1;
    else if (mode == 2 && !flush) mode = 0;
    if (pop) void'(q.pop_front());
    foreach (q[i]) q[i].age++;
    if (g >= 0) begin
      e.id   = g;
      e.dat  = permute(bus.req_dat[g*512 +: 512], bus.req_kp[g*64 +: 64]);
      e.ctrl = bus.req_ctrl[g*4 +: 4];
      e.err  = has_dup(bus.req_kp[g*64 +: 64]);
      e.age  = 0;
      q.push_back(e);
      ptr = (g + 1) % NREQ;
    end
  endtask

  task automatic rand_fields();
    int p[16];
    int j, t;
    for (int r = 0; r < NREQ; r++) begin
      for (int w = 0; w < 16; w++) bus.req_dat[r*512 + w*32 +: 32] = $urandom;
      for (int i = 0; i < 16; i++) p[i] = i;
      for (int i = 15; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = p[i]; p[i] = p[j]; p[j] = t;
      end
      if ($urandom_range(3, 0) == 0) p[$urandom_range(15, 0)] = p[$urandom_range(15, 0)];
      for (int i = 0; i < 16; i++) bus.req_kp[r*64 + 4*i +: 4] = 4'(p[i]);
      bus.req_ctrl[r*4 +: 4] = 4'($urandom);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic rr, input logic fl);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    flush = fl;
    if (!keep_fields) rand_fields();
    @(negedge clk);
    model_cycle();
  endtask

  logic [511:0] lanes_inc;
  int           cnt;
  int           fl_left;

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.req_dat   = '0;
    bus.req_kp    = '0;
    bus.req_ctrl  = '0;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", bus.req_ready, '0);
    chk("rst_t_kp", t_kp_dat, '0);
    chk("rst_flush_done", flush_done, 1'b0);
    chk("rst_rsp_dat", bus.rsp_dat, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Identity map from requester 0, lane i carries i+1.
    for (int i = 0; i < 16; i++) lanes_inc[32*i +: 32] = 32'(i + 1);
    keep_fields = 1'b1;
    bus.req_dat[511:0] = lanes_inc;
    bus.req_kp[63:0]   = 64'hFEDCBA9876543210;
    bus.req_ctrl[3:0]  = 4'h3;
    step(4'b0001, 1'b1, 1'b0);
    chk("ident_grant", bus.req_ready, 4'b0001);
    step(4'b0000, 1'b1, 1'b0);
    chk("ident_lat1", bus.rsp_valid, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("ident_valid", bus.rsp_valid, 1'b1);
    chk("ident_dat", bus.rsp_dat, lanes_inc);
    chk("ident_id", bus.rsp_id, 2'd0);
    chk("ident_err", bus.rsp_err, 1'b0);

    // Duplicate nibble map from requester 2.
    bus.req_kp[2*64 +: 64] = 64'hFEDCBA9876543255;
    bus.req_ctrl[2*4 +: 4] = 4'hA;
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("dup_valid", bus.rsp_valid, 1'b1);
    chk("dup_err", bus.rsp_err, 1'b1);
    chk("dup_ctrl", bus.rsp_ctrl, 4'hA);
    chk("dup_id", bus.rsp_id, 2'd2);
    keep_fields = 1'b0;

    // All requesters continuously valid; pointer sits at 3 after the grant to 2.
    step(4'b1111, 1'b1, 1'b0);
    chk("rr_first", bus.req_ready, 4'b1000);
    repeat (11) step(4'b1111, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 1'b1, 1'b0);

    // Backpressure: three requesters waiting, output stalled for five cycles.
    cnt = 0;
    repeat (5) begin
      step(4'b0111, 1'b0, 1'b0);
      if (bus.req_ready != '0) cnt++;
    end
    chk("bp_accepts", 32'(cnt), 32'd2);
    repeat (6) step(4'b0111, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 1'b1, 1'b0);

    // Flush with two entries in flight.
    repeat (2) step(4'b1111, 1'b1, 1'b0);
    fd_seen = 0;
    step(4'b1111, 1'b1, 1'b1);
    chk("flush_no_grant", bus.req_ready, '0);
    repeat (5) step(4'b1111, 1'b1, 1'b1);
    chk("flush_pulses", 32'(fd_seen), 32'd1);
    repeat (6) step(4'b1111, 1'b1, 1'b0);

    // Randomized traffic with occasional flush episodes.
    fl_left = 0;
    repeat (600) begin
      if (fl_left > 0) fl_left--;
      else if ($urandom_range(49, 0) == 0) fl_left = $urandom_range(10, 3);
      step(NREQ'($urandom), ($urandom_range(9, 0) < 7), fl_left > 0);
    end
    repeat (4) step(4'b0000, 1'b1, 1'b0);

    // Reset with both stages full.
    repeat (3) step(4'b1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("mid_rst_valid", bus.rsp_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    q.delete();
    ptr  = 0;
    mode = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step(4'b1111, 1'b1, 1'b0);
    chk("post_rst_grant", bus.req_ready, 4'b0001);
    repeat (8) step(4'b1111, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
